// File: rtl/ysyx_24100005_imem_responder.sv
// ysyx_24100005_imem_responder: instruction-memory responder with valid/ready fetch and programmable latency
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_addr fetch request;
// resp_valid/resp_ready/resp_inst/resp_err response; wr_en/wr_idx/wr_data preload port.
// IMEM_EBREAK_ON_ERR_EN selects ebreak as the fault word instead of zero.
module ysyx_24100005_imem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data
);
`ifdef IMEM_EBREAK_ON_ERR_EN
  localparam logic [31:0] FAULT_WORD = 32'h0010_0073;
`else
  localparam logic [31:0] FAULT_WORD = 32'h0000_0000;
`endif
  localparam logic [32:0] SPAN = 33'(1) << (DEPTH_LOG2 + 2);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           inst_q, inst_d;
  logic                  err_q, err_d;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0]           off;
  logic                  fault;
  logic [DEPTH_LOG2-1:0] idx;
  // wrapping subtract folds addresses below BASE_ADDR into the out-of-range check
  assign off        = req_addr - BASE_ADDR;
  assign fault      = (req_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
  assign idx        = off[DEPTH_LOG2+1:2];
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = state_q == RESP;
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    if (state_q == IDLE && req_valid) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d   = (LATENCY == 1) ? 4'd0 : 4'(LATENCY - 2);
      // memory read here precedes any same-edge preload write, so the old word is captured
      inst_d  = fault ? FAULT_WORD : mem[idx];
      err_d   = fault;
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd0) ? RESP : WAIT;
      cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end
  // preload is independent of reset and state; contents are never cleared
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_ysyx_24100005_imem_responder.sv
// tb_ysyx_24100005_imem_responder: directed bench for the imem responder at latencies 1, 4 and 8
module tb_ysyx_24100005_imem_responder;
`ifdef IMEM_EBREAK_ON_ERR_EN
  localparam logic [31:0] FW = 32'h0010_0073;
`else
  localparam logic [31:0] FW = 32'h0000_0000;
`endif
  logic        clk = 0;
  logic        rst;
  logic [2:0]  qv;
  logic [2:0]  rqr;
  logic [31:0] req_addr;
  logic [2:0]  rv;
  logic        resp_ready;
  logic [31:0] ri [3];
  logic [2:0]  re;
  logic        wr_en;
  logic [9:0]  wr_idx;
  logic [31:0] wr_data;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  ysyx_24100005_imem_responder #(.LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(qv[0]), .req_ready(rqr[0]), .req_addr(req_addr),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_inst(ri[0]), .resp_err(re[0]),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));
  ysyx_24100005_imem_responder #(.LATENCY(4)) u1 (
    .clk(clk), .rst(rst), .req_valid(qv[1]), .req_ready(rqr[1]), .req_addr(req_addr),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_inst(ri[1]), .resp_err(re[1]),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));
  ysyx_24100005_imem_responder #(.LATENCY(8)) u2 (
    .clk(clk), .rst(rst), .req_valid(qv[2]), .req_ready(rqr[2]), .req_addr(req_addr),
    .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_inst(ri[2]), .resp_err(re[2]),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [9:0] i, input logic [31:0] d);
    wr_en = 1; wr_idx = i; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic fetch(input int d, input logic [31:0] a, input int lat, input logic [31:0] ei,
                       input logic ee, input string tag);
    int c;
    req_addr = a; qv[d] = 1;
    @(negedge clk);
    qv[d] = 0; wr_en = 0;
    c = 0;
    while (!rv[d] && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, 32'(c), 32'(lat));
    check({tag, "_inst"}, ri[d], ei);
    check({tag, "_err"}, 32'(re[d]), 32'(ee));
    @(negedge clk);
    check({tag, "_done"}, {30'd0, rv[d], rqr[d]}, 32'd1);
  endtask
  initial begin
    logic seen;
    rst = 1; qv = 0; req_addr = 0; resp_ready = 1; wr_en = 0; wr_idx = 0; wr_data = 0;
    @(negedge clk);
    check("rst_req_ready", 32'(rqr), 32'd0);
    wr(10'd0, 32'h0000_0413);
    wr(10'd1, 32'h00A0_0093);
    wr(10'd2, 32'hCAFE_F00D);
    wr(10'd3, 32'h1111_1111);
    wr(10'd1023, 32'h1234_5678);
    check("rst_resp_valid", 32'(rv), 32'd0);
    check("rst_resp_inst", ri[0], 32'd0);
    check("rst_resp_err", 32'(re), 32'd0);
    rst = 0; #1;
    check("post_rst_req_ready", 32'(rqr), 32'd7);
    @(negedge clk);
    fetch(0, 32'h8000_0000, 0, 32'h0000_0413, 1'b0, "l1_word0");
    fetch(1, 32'h8000_0004, 3, 32'h00A0_0093, 1'b0, "l4_word1");
    fetch(0, 32'h8000_0002, 0, FW, 1'b1, "misalign");
    fetch(0, 32'h7FFF_FFFC, 0, FW, 1'b1, "below_base");
    fetch(0, 32'h8000_1000, 0, FW, 1'b1, "past_end");
    fetch(1, 32'h8000_1000, 3, FW, 1'b1, "l4_past_end");
    fetch(0, 32'h8000_0FFC, 0, 32'h1234_5678, 1'b0, "last_word");
    resp_ready = 0; req_addr = 32'h8000_0008; qv[0] = 1;
    @(negedge clk);
    qv[0] = 0;
    check("bp_valid", 32'(rv[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_idx = 10'd2; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("bp_hold_inst", ri[0], 32'hCAFE_F00D);
      check("bp_hold_hs", {30'd0, rv[0], rqr[0]}, 32'd2);
    end
    wr_en = 0; resp_ready = 1;
    @(negedge clk);
    check("bp_release", {30'd0, rv[0], rqr[0]}, 32'd1);
    fetch(0, 32'h8000_0008, 0, 32'hDEAD_BEEF, 1'b0, "bp_new_word");
    wr_en = 1; wr_idx = 10'd3; wr_data = 32'h2222_2222;
    fetch(0, 32'h8000_000C, 0, 32'h1111_1111, 1'b0, "rbw_old");
    fetch(0, 32'h8000_000C, 0, 32'h2222_2222, 1'b0, "rbw_new");
    req_addr = 32'h8000_0000; qv[2] = 1;
    @(negedge clk);
    qv[2] = 0;
    check("l8_wait_valid", 32'(rv[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; #1;
    check("midrst_req_ready", 32'(rqr[2]), 32'd1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= rv[2];
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    fetch(2, 32'h8000_0004, 7, 32'h00A0_0093, 1'b0, "l8_word1");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
